// File: rtl/int8_mac_pkg.sv
// Shared types and constants for the int8_mac dot-product sequencer.
// Feature macro MAC_SEQ_CTRL_OVF_EN is consumed by int8_mac_seq_ctrl, not here.
package int8_mac_pkg;

    localparam int PSUM_W        = 24;
    localparam int LANES         = 33;
    localparam int CHUNK_W       = 264;
    localparam int MAX_CHUNK_SUM = 2145825;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Travels alongside each SRAM read so the MAC side knows where a job starts and ends.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/int8_mac_seq_ctrl_if.sv
// Command/result port bundle between the tile scheduler (master) and the sequencer (slave).
interface int8_mac_seq_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
);
    import int8_mac_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic [ADDR_W-1:0] cmd_a_base;
    logic [ADDR_W-1:0] cmd_b_base;
    logic              res_valid;
    logic              res_ready;
    logic [PSUM_W-1:0] res_data;
    logic              res_ovf;

    modport master (
        output cmd_valid, cmd_len, cmd_a_base, cmd_b_base, res_ready,
        input  cmd_ready, res_valid, res_data, res_ovf
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_a_base, cmd_b_base, res_ready,
        output cmd_ready, res_valid, res_data, res_ovf
    );

endinterface

// File: rtl/int8_mac_seq_tag_pipe.sv
// RD_LAT-deep shift register that delays read tags to line up with SRAM read data.
module int8_mac_seq_tag_pipe
    import int8_mac_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_reg [RD_LAT];

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= '0;
                    else        stage_reg[gi] <= tag_in;
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= '0;
                    else        stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign tag_out = stage_reg[RD_LAT-1];

endmodule

// File: rtl/int8_mac_seq_ctrl.sv
// Job sequencer for one int8_mac engine: streams K operand chunks, closes the psum loop, returns the result.
// Optional wrap detection enabled by defining MAC_SEQ_CTRL_OVF_EN.
module int8_mac_seq_ctrl
    import int8_mac_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    int8_mac_seq_ctrl_if.slave host,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_a_addr,
    output logic [ADDR_W-1:0] rd_b_addr,
    output logic              mac_en,
    output logic [PSUM_W-1:0] mac_psum_in,
    input  logic [PSUM_W-1:0] mac_psum_out,
    output logic              busy
);

    state_t            state_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic              rd_en_reg;
    logic              first_reg;
    logic              last_reg;
    logic [ADDR_W-1:0] a_addr_reg;
    logic [ADDR_W-1:0] b_addr_reg;
    logic              cap_reg;
    logic              cmd_ready_reg;
    logic              busy_reg;
    logic              res_valid_reg;
    logic [PSUM_W-1:0] res_data_reg;
    logic              res_ovf_reg;
    logic              ovf_cap;
    logic              accept;
    tag_t              tag_in;
    tag_t              tag_out;

    assign tag_in = '{vld: rd_en_reg, first: first_reg, last: last_reg};

    int8_mac_seq_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign accept = (state_reg == IDLE) && host.cmd_valid;

    // The first chunk of a job starts from zero; later chunks feed the MAC its own output back.
    assign mac_en      = tag_out.vld;
    assign mac_psum_in = (tag_out.vld && !tag_out.first) ? mac_psum_out : '0;

`ifdef MAC_SEQ_CTRL_OVF_EN
    logic              chk_reg;
    logic [PSUM_W-1:0] fed_reg;
    logic              ovf_q;
    logic              wrap_now;

    // A single chunk can never add 2^24 or more, so any decrease means the sum wrapped.
    assign wrap_now = chk_reg && (mac_psum_out < fed_reg);
    assign ovf_cap  = ovf_q | wrap_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_reg <= 1'b0;
            fed_reg <= '0;
            ovf_q   <= 1'b0;
        end else begin
            chk_reg <= tag_out.vld & ~tag_out.first;
            fed_reg <= mac_psum_in;
            if (accept)        ovf_q <= 1'b0;
            else if (wrap_now) ovf_q <= 1'b1;
        end
    end
`else
    assign ovf_cap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rd_en_reg     <= 1'b0;
            first_reg     <= 1'b0;
            last_reg      <= 1'b0;
            a_addr_reg    <= '0;
            b_addr_reg    <= '0;
            cap_reg       <= 1'b0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_ovf_reg   <= 1'b0;
        end else begin
            cap_reg <= tag_out.vld & tag_out.last;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (host.cmd_len == '0) begin
                            state_reg     <= DONE;
                            res_valid_reg <= 1'b1;
                            res_data_reg  <= '0;
                            res_ovf_reg   <= 1'b0;
                        end else begin
                            state_reg  <= ISSUE;
                            rd_en_reg  <= 1'b1;
                            first_reg  <= 1'b1;
                            last_reg   <= (host.cmd_len == LEN_W'(1));
                            cnt_reg    <= host.cmd_len - LEN_W'(1);
                            a_addr_reg <= host.cmd_a_base;
                            b_addr_reg <= host.cmd_b_base;
                        end
                    end
                end
                ISSUE: begin
                    first_reg <= 1'b0;
                    if (cnt_reg == '0) begin
                        state_reg <= DRAIN;
                        rd_en_reg <= 1'b0;
                        last_reg  <= 1'b0;
                    end else begin
                        cnt_reg    <= cnt_reg - LEN_W'(1);
                        last_reg   <= (cnt_reg == LEN_W'(1));
                        a_addr_reg <= a_addr_reg + ADDR_W'(1);
                        b_addr_reg <= b_addr_reg + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // MAC clears once mac_en drops, so the final sum must be grabbed now.
                    if (cap_reg) begin
                        state_reg     <= DONE;
                        res_valid_reg <= 1'b1;
                        res_data_reg  <= mac_psum_out;
                        res_ovf_reg   <= ovf_cap;
                    end
                end
                DONE: begin
                    if (host.res_ready) begin
                        state_reg     <= IDLE;
                        res_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign host.cmd_ready = cmd_ready_reg;
    assign host.res_valid = res_valid_reg;
    assign host.res_data  = res_data_reg;
    assign host.res_ovf   = res_ovf_reg;
    assign rd_en          = rd_en_reg;
    assign rd_a_addr      = a_addr_reg;
    assign rd_b_addr      = b_addr_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_int8_mac_seq_ctrl.sv
// Self-checking bench: sequencer + SRAM model + int8_mac model, checked against a plain-arithmetic dot product.
module tb_int8_mac_seq_ctrl;
    import int8_mac_pkg::*;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 8;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int8_mac_seq_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    logic              rd_en;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [ADDR_W-1:0] rd_b_addr;
    logic              mac_en;
    logic [PSUM_W-1:0] mac_psum_in;
    logic [PSUM_W-1:0] mac_psum_out;
    logic              busy;

    int8_mac_seq_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host         (bus.slave),
        .rd_en        (rd_en),
        .rd_a_addr    (rd_a_addr),
        .rd_b_addr    (rd_b_addr),
        .mac_en       (mac_en),
        .mac_psum_in  (mac_psum_in),
        .mac_psum_out (mac_psum_out),
        .busy         (busy)
    );

    // Operand SRAMs with RD_LAT-cycle registered read
    logic [CHUNK_W-1:0] mem_a [DEPTH];
    logic [CHUNK_W-1:0] mem_b [DEPTH];
    logic [CHUNK_W-1:0] pipe_a [RD_LAT];
    logic [CHUNK_W-1:0] pipe_b [RD_LAT];

    always @(posedge clk) begin
        pipe_a[0] <= mem_a[rd_a_addr];
        pipe_b[0] <= mem_b[rd_b_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end

    function automatic logic [PSUM_W-1:0] chunk_dot(input logic [CHUNK_W-1:0] a, input logic [CHUNK_W-1:0] b);
        int unsigned s;
        s = 0;
        for (int l = 0; l < LANES; l++) s += int'(a[l*8 +: 8]) * int'(b[l*8 +: 8]);
        return PSUM_W'(s);
    endfunction

    // int8_mac engine: registered partial sum, cleared whenever it is not enabled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mac_psum_out <= '0;
        else if (mac_en) mac_psum_out <= mac_psum_in + chunk_dot(pipe_a[RD_LAT-1], pipe_b[RD_LAT-1]);
        else             mac_psum_out <= '0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the most recent job
    int                obs_rd_cnt, obs_mac_cnt, obs_mac_first, obs_mac_last, obs_res_cycle;
    int                obs_hold_bad;
    logic              obs_timeout, obs_pre_ready;
    logic [PSUM_W-1:0] obs_data;
    logic              obs_ovf;
    logic              obs_after_valid, obs_after_ready, obs_after_busy;
    logic [ADDR_W-1:0] obs_a[$];
    logic [ADDR_W-1:0] obs_b[$];

    task automatic fill(input logic [ADDR_W-1:0] base_a, input logic [ADDR_W-1:0] base_b,
                        input int k, input bit rnd, input logic [7:0] va, input logic [7:0] vb);
        logic [ADDR_W-1:0] aa, bb;
        logic [CHUNK_W-1:0] ca, cb;
        for (int i = 0; i < k; i++) begin
            aa = base_a + ADDR_W'(i);
            bb = base_b + ADDR_W'(i);
            for (int l = 0; l < LANES; l++) begin
                ca[l*8 +: 8] = rnd ? 8'($urandom) : va;
                cb[l*8 +: 8] = rnd ? 8'($urandom) : vb;
            end
            mem_a[aa] = ca;
            mem_b[bb] = cb;
        end
    endtask

    // Exact (unwrapped) dot product over the job's chunks
    function automatic longint ref_total(input logic [ADDR_W-1:0] base_a, input logic [ADDR_W-1:0] base_b, input int k);
        longint t;
        logic [ADDR_W-1:0] aa, bb;
        t = 0;
        for (int i = 0; i < k; i++) begin
            aa = base_a + ADDR_W'(i);
            bb = base_b + ADDR_W'(i);
            for (int l = 0; l < LANES; l++)
                t += longint'(mem_a[aa][l*8 +: 8]) * longint'(mem_b[bb][l*8 +: 8]);
        end
        return t;
    endfunction

    function automatic logic ref_ovf(input longint t);
`ifdef MAC_SEQ_CTRL_OVF_EN
        return t >= (longint'(1) << 24);
`else
        return (t < 0);
`endif
    endfunction

    function automatic int exp_cycle(input int k);
        return (k == 0) ? 1 : k + RD_LAT + 2;
    endfunction

    // Drives one job, records what the DUT did; comparisons live in the test tasks.
    task automatic run_job(input int k, input logic [ADDR_W-1:0] a_base, input logic [ADDR_W-1:0] b_base, input int hold);
        int cyc;
        bit done;
        obs_a.delete(); obs_b.delete();
        obs_rd_cnt = 0; obs_mac_cnt = 0; obs_mac_first = -1; obs_mac_last = -1;
        obs_res_cycle = -1; obs_hold_bad = 0; obs_data = 'x; obs_ovf = 1'bx;
        obs_pre_ready = bus.cmd_ready;
        bus.cmd_valid = 1'b1; bus.cmd_len = LEN_W'(k); bus.cmd_a_base = a_base; bus.cmd_b_base = b_base;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        cyc = 1; done = 0;
        while (!done && cyc < 400) begin
            if (rd_en) begin obs_rd_cnt++; obs_a.push_back(rd_a_addr); obs_b.push_back(rd_b_addr); end
            if (mac_en) begin
                obs_mac_cnt++;
                if (obs_mac_first < 0) obs_mac_first = cyc;
                obs_mac_last = cyc;
            end
            if (bus.res_valid) begin
                done = 1; obs_res_cycle = cyc; obs_data = bus.res_data; obs_ovf = bus.res_ovf;
            end else begin
                @(posedge clk); #1; cyc++;
            end
        end
        obs_timeout = !done;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (bus.res_valid !== 1'b1 || bus.res_data !== obs_data || bus.res_ovf !== obs_ovf || bus.cmd_ready !== 1'b0)
                obs_hold_bad++;
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        obs_after_valid = bus.res_valid; obs_after_ready = bus.cmd_ready; obs_after_busy = busy;
        $display("job K=%0d a_base=%h b_base=%h res=%0d ovf=%0b res_cycle=%0d reads=%0d macs=%0d",
                 k, a_base, b_base, obs_data, obs_ovf, obs_res_cycle, obs_rd_cnt, obs_mac_cnt);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
        n_checks++; if (mac_en !== 1'b0) begin n_fail++; $display("FAIL reset_mac_en got=%b exp=0", mac_en); end
        n_checks++; if (rd_a_addr !== '0 || rd_b_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%h/%h exp=0", rd_a_addr, rd_b_addr); end
        n_checks++; if (mac_psum_in !== '0) begin n_fail++; $display("FAIL reset_psum_in got=%h exp=0", mac_psum_in); end
        n_checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== '0 || bus.res_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_res got=%b/%h/%b exp=0/0/0", bus.res_valid, bus.res_data, bus.res_ovf); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [ADDR_W-1:0] a0, b0;
        a0 = ADDR_W'($urandom); b0 = ADDR_W'($urandom);
        fill(a0, b0, 1, 0, 8'd1, 8'd1);
        run_job(1, a0, b0, 0);
        n_checks++; if (obs_pre_ready !== 1'b1) begin n_fail++; $display("FAIL single_cmd_ready got=%b exp=1", obs_pre_ready); end
        n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout got=%b exp=0", obs_timeout); end
        n_checks++; if (obs_data !== 24'd33) begin n_fail++; $display("FAIL single_data got=%0d exp=33", obs_data); end
        n_checks++; if (obs_res_cycle !== 4) begin n_fail++; $display("FAIL single_res_cycle got=%0d exp=4", obs_res_cycle); end
        n_checks++; if (obs_rd_cnt !== 1 || obs_mac_cnt !== 1) begin n_fail++; $display("FAIL single_counts got=%0d/%0d exp=1/1", obs_rd_cnt, obs_mac_cnt); end
        n_checks++; if (obs_after_ready !== 1'b1 || obs_after_busy !== 1'b0 || obs_after_valid !== 1'b0) begin n_fail++; $display("FAIL single_after got=%b/%b/%b exp=1/0/0", obs_after_ready, obs_after_busy, obs_after_valid); end
    endtask

    task automatic test_k3();
        logic [ADDR_W-1:0] a0, b0;
        a0 = ADDR_W'(10'h100); b0 = ADDR_W'(10'h050);
        fill(a0, b0, 3, 0, 8'd2, 8'd3);
        run_job(3, a0, b0, 0);
        n_checks++; if (obs_data !== 24'd594) begin n_fail++; $display("FAIL k3_data got=%0d exp=594", obs_data); end
        n_checks++; if (obs_mac_cnt !== 3) begin n_fail++; $display("FAIL k3_mac_cnt got=%0d exp=3", obs_mac_cnt); end
        n_checks++; if (obs_mac_first !== 1 + RD_LAT || obs_mac_last !== 3 + RD_LAT) begin n_fail++; $display("FAIL k3_mac_window got=%0d..%0d exp=%0d..%0d", obs_mac_first, obs_mac_last, 1 + RD_LAT, 3 + RD_LAT); end
        n_checks++; if (obs_rd_cnt !== 3) begin n_fail++; $display("FAIL k3_rd_cnt got=%0d exp=3", obs_rd_cnt); end
        for (int i = 0; i < obs_a.size() && i < 3; i++) begin
            n_checks++; if (obs_a[i] !== a0 + ADDR_W'(i) || obs_b[i] !== b0 + ADDR_W'(i)) begin n_fail++; $display("FAIL k3_addr[%0d] got=%h/%h exp=%h/%h", i, obs_a[i], obs_b[i], a0 + ADDR_W'(i), b0 + ADDR_W'(i)); end
        end
        n_checks++; if (obs_res_cycle !== exp_cycle(3)) begin n_fail++; $display("FAIL k3_res_cycle got=%0d exp=%0d", obs_res_cycle, exp_cycle(3)); end
    endtask

    task automatic test_hold();
        logic [ADDR_W-1:0] a0, b0;
        longint t;
        a0 = ADDR_W'($urandom); b0 = ADDR_W'($urandom);
        fill(a0, b0, 2, 1, 8'd0, 8'd0);
        t = ref_total(a0, b0, 2);
        run_job(2, a0, b0, 10);
        n_checks++; if (obs_data !== PSUM_W'(t)) begin n_fail++; $display("FAIL hold_data got=%0d exp=%0d", obs_data, PSUM_W'(t)); end
        n_checks++; if (obs_hold_bad !== 0) begin n_fail++; $display("FAIL hold_stable got=%0d bad cycles exp=0", obs_hold_bad); end
        n_checks++; if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin n_fail++; $display("FAIL hold_accept got=%b/%b exp=0/1", obs_after_valid, obs_after_ready); end
    endtask

    task automatic test_zero();
        run_job(0, ADDR_W'($urandom), ADDR_W'($urandom), 0);
        n_checks++; if (obs_rd_cnt !== 0 || obs_mac_cnt !== 0) begin n_fail++; $display("FAIL zero_activity got=%0d/%0d exp=0/0", obs_rd_cnt, obs_mac_cnt); end
        n_checks++; if (obs_data !== '0) begin n_fail++; $display("FAIL zero_data got=%0d exp=0", obs_data); end
        n_checks++; if (obs_res_cycle !== 1) begin n_fail++; $display("FAIL zero_res_cycle got=%0d exp=1", obs_res_cycle); end
    endtask

    task automatic test_wrap_ovf();
        logic [ADDR_W-1:0] a0, b0;
        logic exp_ovf;
`ifdef MAC_SEQ_CTRL_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        a0 = ADDR_W'(10'h200); b0 = ADDR_W'(10'h300);
        fill(a0, b0, 8, 0, 8'd255, 8'd255);
        run_job(8, a0, b0, 0);
        n_checks++; if (obs_data !== 24'd389384) begin n_fail++; $display("FAIL ovf_data got=%0d exp=389384", obs_data); end
        n_checks++; if (obs_ovf !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag got=%b exp=%b", obs_ovf, exp_ovf); end
        // A clean job afterwards must not inherit the sticky flag
        fill(a0, b0, 2, 0, 8'd1, 8'd1);
        run_job(2, a0, b0, 0);
        n_checks++; if (obs_ovf !== 1'b0 || obs_data !== 24'd66) begin n_fail++; $display("FAIL ovf_clear got=%b/%0d exp=0/66", obs_ovf, obs_data); end
    endtask

    task automatic test_addr_wrap();
        logic [ADDR_W-1:0] exp_a [4];
        logic [ADDR_W-1:0] b0;
        longint t;
        exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
        b0 = ADDR_W'($urandom);
        fill(exp_a[0], b0, 4, 1, 8'd0, 8'd0);
        t = ref_total(exp_a[0], b0, 4);
        run_job(4, exp_a[0], b0, 0);
        n_checks++; if (obs_a.size() !== 4) begin n_fail++; $display("FAIL wrap_rd_cnt got=%0d exp=4", obs_a.size()); end
        for (int i = 0; i < obs_a.size() && i < 4; i++) begin
            n_checks++; if (obs_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, obs_a[i], exp_a[i]); end
        end
        n_checks++; if (obs_data !== PSUM_W'(t)) begin n_fail++; $display("FAIL wrap_data got=%0d exp=%0d", obs_data, PSUM_W'(t)); end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a0, b0;
        longint t;
        int k;
        for (int j = 0; j < 12; j++) begin
            k  = $urandom_range(1, 24);
            a0 = ADDR_W'($urandom); b0 = ADDR_W'($urandom);
            fill(a0, b0, k, 1, 8'd0, 8'd0);
            t = ref_total(a0, b0, k);
            run_job(k, a0, b0, $urandom_range(0, 3));
            n_checks++; if (obs_data !== PSUM_W'(t) || obs_ovf !== ref_ovf(t)) begin n_fail++; $display("FAIL rand%0d_res got=%0d/%b exp=%0d/%b", j, obs_data, obs_ovf, PSUM_W'(t), ref_ovf(t)); end
            n_checks++; if (obs_res_cycle !== exp_cycle(k) || obs_mac_cnt !== k) begin n_fail++; $display("FAIL rand%0d_timing got=%0d/%0d exp=%0d/%0d", j, obs_res_cycle, obs_mac_cnt, exp_cycle(k), k); end
        end
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W-1:0] a0, b0;
        longint t;
        a0 = ADDR_W'($urandom); b0 = ADDR_W'($urandom);
        fill(a0, b0, 10, 1, 8'd0, 8'd0);
        bus.cmd_valid = 1'b1; bus.cmd_len = LEN_W'(10); bus.cmd_a_base = a0; bus.cmd_b_base = b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (rd_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_active got=%b/%b exp=1/1", rd_en, busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (rd_en !== 1'b0 || mac_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got=%b/%b/%b exp=0/0/0", rd_en, mac_en, busy); end
        n_checks++; if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || rd_a_addr !== '0 || mac_psum_in !== '0) begin n_fail++; $display("FAIL midrst_outs got=%b/%b/%h/%h exp=1/0/0/0", bus.cmd_ready, bus.res_valid, rd_a_addr, mac_psum_in); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        a0 = ADDR_W'($urandom); b0 = ADDR_W'($urandom);
        fill(a0, b0, 5, 1, 8'd0, 8'd0);
        t = ref_total(a0, b0, 5);
        run_job(5, a0, b0, 0);
        n_checks++; if (obs_data !== PSUM_W'(t) || obs_res_cycle !== exp_cycle(5)) begin n_fail++; $display("FAIL midrst_next got=%0d@%0d exp=%0d@%0d", obs_data, obs_res_cycle, PSUM_W'(t), exp_cycle(5)); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_a_base = '0; bus.cmd_b_base = '0; bus.res_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        test_reset();
        test_single();
        test_k3();
        test_hold();
        test_zero();
        test_wrap_ovf();
        test_addr_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
